// File: rtl/alu_req_driver_if.sv
// Host request/response and ALU operand/result bundle for alu_req_driver.
// master: the driver; slave: the host plus ALU side it talks to.
interface alu_req_driver_if #(
  parameter int DW = 8,
  parameter int CW = 4
);
  logic          REQ_VALID;
  logic          REQ_READY;
  logic [DW-1:0] REQ_OPA;
  logic [DW-1:0] REQ_OPB;
  logic [CW-1:0] REQ_CMD;
  logic          REQ_MODE;
  logic          REQ_CIN;
  logic [1:0]    REQ_SPLIT;
  logic [4:0]    REQ_GAP;

  logic [DW-1:0] ALU_OPA;
  logic [DW-1:0] ALU_OPB;
  logic [CW-1:0] ALU_CMD;
  logic          ALU_MODE;
  logic          ALU_CIN;
  logic          ALU_CE;
  logic [1:0]    ALU_INP_VALID;
  logic [DW+1:0] ALU_RES;
  logic          ALU_COUT;
  logic          ALU_OFLOW;
  logic          ALU_G;
  logic          ALU_E;
  logic          ALU_L;
  logic          ALU_ERR;

  logic          RSP_VALID;
  logic          RSP_READY;
  logic [DW+1:0] RSP_RES;
  logic [5:0]    RSP_FLAGS;
  logic          RSP_LATE;

  modport master (
    input  REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD,
    input  REQ_MODE, REQ_CIN, REQ_SPLIT, REQ_GAP,
    output REQ_READY,
    output ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE,
    output ALU_CIN, ALU_CE, ALU_INP_VALID,
    input  ALU_RES, ALU_COUT, ALU_OFLOW,
    input  ALU_G, ALU_E, ALU_L, ALU_ERR,
    output RSP_VALID, RSP_RES, RSP_FLAGS, RSP_LATE,
    input  RSP_READY
  );

  modport slave (
    output REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD,
    output REQ_MODE, REQ_CIN, REQ_SPLIT, REQ_GAP,
    input  REQ_READY,
    input  ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE,
    input  ALU_CIN, ALU_CE, ALU_INP_VALID,
    output ALU_RES, ALU_COUT, ALU_OFLOW,
    output ALU_G, ALU_E, ALU_L, ALU_ERR,
    input  RSP_VALID, RSP_RES, RSP_FLAGS, RSP_LATE,
    output RSP_READY
  );
endinterface

// File: rtl/alu_req_driver.sv
// ALU initiator: issues one operation (whole or split with idle gap),
// waits the fixed result latency and hands the result back to the host.
module alu_req_driver #(
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int LAT     = 2,
  parameter int MUL_LAT = 3
) (
  input logic         CLK,
  input logic         RST,
  alu_req_driver_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, ISSUE1, GAP, ISSUE2, WAIT, RESP
  } state_t;

  state_t state, state_nxt;
  logic [4:0] cnt, cnt_nxt;

  logic [DW-1:0] r_opa, r_opb;
  logic [CW-1:0] r_cmd;
  logic          r_mode, r_cin;
  logic [1:0]    r_split;
  logic [4:0]    r_gap;
  logic [DW+1:0] r_res;
  logic [5:0]    r_flags;

  logic       accept, capture, split, two_stage;
  logic [4:0] wait_n;
  logic [1:0] iv;

  assign split = (r_split == 2'b01) || (r_split == 2'b10);
  assign two_stage = r_mode &&
    (r_cmd == CW'(9) || r_cmd == CW'(10));
  assign wait_n = two_stage ? 5'(MUL_LAT) : 5'(LAT);
  assign accept = (state == IDLE) && bus.REQ_VALID;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.REQ_VALID) state_nxt = ISSUE1;
      end
      ISSUE1: begin
        if (!split) begin
          state_nxt = WAIT;
          cnt_nxt   = wait_n;
        end else if (r_gap != 5'd0) begin
          state_nxt = GAP;
          cnt_nxt   = r_gap;
        end else begin
          state_nxt = ISSUE2;
        end
      end
      GAP: begin
        if (cnt == 5'd1) state_nxt = ISSUE2;
        else cnt_nxt = cnt - 5'd1;
      end
      ISSUE2: begin
        state_nxt = WAIT;
        cnt_nxt   = wait_n;
      end
      WAIT: begin
        if (cnt == 5'd1) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      RESP: begin
        if (bus.RSP_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_cmd   <= '0;
      r_mode  <= 1'b0;
      r_cin   <= 1'b0;
      r_split <= '0;
      r_gap   <= '0;
      r_res   <= '0;
      r_flags <= '0;
    end else begin
      if (accept) begin
        r_opa   <= bus.REQ_OPA;
        r_opb   <= bus.REQ_OPB;
        r_cmd   <= bus.REQ_CMD;
        r_mode  <= bus.REQ_MODE;
        r_cin   <= bus.REQ_CIN;
        r_split <= bus.REQ_SPLIT;
        r_gap   <= bus.REQ_GAP;
      end
      if (capture) begin
        r_res   <= bus.ALU_RES;
        r_flags <= {bus.ALU_COUT, bus.ALU_OFLOW,
                    bus.ALU_G, bus.ALU_E,
                    bus.ALU_L, bus.ALU_ERR};
      end
    end
  end

  // Second half is the complement of the first: 01 -> 10, 10 -> 01.
  always_comb begin
    iv = 2'b00;
    unique case (1'b1)
      (state == ISSUE1): iv = split ? r_split : 2'b11;
      (state == ISSUE2): iv = ~r_split;
      default:           iv = 2'b00;
    endcase
  end

  assign bus.REQ_READY     = (state == IDLE) && !RST;
  assign bus.ALU_OPA       = r_opa;
  assign bus.ALU_OPB       = r_opb;
  assign bus.ALU_CMD       = r_cmd;
  assign bus.ALU_MODE      = r_mode;
  assign bus.ALU_CIN       = r_cin;
  assign bus.ALU_CE        = (state == ISSUE1) ||
                             (state == GAP) ||
                             (state == ISSUE2) ||
                             (state == WAIT);
  assign bus.ALU_INP_VALID = iv;
  assign bus.RSP_VALID     = (state == RESP);
  assign bus.RSP_RES       = r_res;
  assign bus.RSP_FLAGS     = r_flags;
  assign bus.RSP_LATE      = split && r_gap[4];

endmodule

// File: doc/alu_req_driver.md
Name: alu_req_driver

Overview:
- Initiator side of the ALU operand/command interface.
- Accepts one complete ALU operation per valid/ready request from a host.
- Drives it onto the ALU's INP_VALID operand bus, either both operands in one cycle or split into two halves separated by a programmable idle gap.
- Waits the fixed ALU result latency, captures RES and flags, and returns them to the host through a valid/ready response port.

Parameters:
- DW, 8, operand width.
- CW, 4, command width.
- LAT, 2, cycles from last operand-issue edge to result-sample edge for single-stage commands.
- MUL_LAT, 3, same for two-stage commands (MODE=1 with CMD 9 or 10).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- REQ_VALID  in  1  host request valid.
- REQ_READY  out  1  driver can accept a request.
- REQ_OPA  in  DW  operand A.
- REQ_OPB  in  DW  operand B.
- REQ_CMD  in  CW  command.
- REQ_MODE  in  1  1=arithmetic, 0=logical.
- REQ_CIN  in  1  carry in.
- REQ_SPLIT  in  2  00=both together; 01=A first then B; 10=B first then A; 11 treated as 00.
- REQ_GAP  in  5  idle cycles between halves (split only).
- ALU_OPA  out  DW  to ALU OPA.
- ALU_OPB  out  DW  to ALU OPB.
- ALU_CMD  out  CW  to ALU CMD.
- ALU_MODE  out  1  to ALU MODE.
- ALU_CIN  out  1  to ALU CIN.
- ALU_CE  out  1  to ALU CE.
- ALU_INP_VALID  out  2  to ALU INP_VALID.
- ALU_RES  in  DW+2  from ALU RES.
- ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR  in  1 each  ALU flags.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  host accepts response.
- RSP_RES  out  DW+2  captured result.
- RSP_FLAGS  out  6  captured {COUT,OFLOW,G,E,L,ERR}.
- RSP_LATE  out  1  split request with gap >= 16; the ALU will flag it late.

Behaviour:
- **Reset.** On RST, all outputs go to 0, the FSM goes to IDLE, the captured request and response are cleared, and any in-flight operation is abandoned with no response. REQ_READY=1 in the cycle after reset.
- **States.** IDLE, ISSUE1, GAP, ISSUE2, WAIT, RESP.
- **IDLE.**
  - REQ_READY=1, ALU_CE=0, ALU_INP_VALID=00.
  - On REQ_VALID, register all REQ_* fields and go to ISSUE1.
- **ISSUE1 (1 cycle).**
  - ALU_CE=1.
  - ALU_CMD/MODE/CIN come from the registered request and are held constant from ISSUE1 through WAIT.
  - SPLIT 00/11: INP_VALID=11, OPA/OPB driven, go to WAIT.
  - SPLIT 01: INP_VALID=01 with OPA.
  - SPLIT 10: INP_VALID=10 with OPB.
  - Split cases go to GAP if REQ_GAP≠0, else to ISSUE2.
- **GAP.**
  - INP_VALID=00, CE=1.
  - Down-counter loaded with REQ_GAP counts exactly REQ_GAP cycles, then goes to ISSUE2.
- **ISSUE2 (1 cycle).** Drives the remaining half (INP_VALID=10 with OPB, or 01 with OPA), then goes to WAIT.
- **OPA/OPB outside the driving half.** These buses carry the registered operand at all times during the operation; only INP_VALID qualifies them.
- **WAIT.**
  - INP_VALID=00, CE=1.
  - Runs for N cycles: N=MUL_LAT if MODE=1 and CMD∈{9,10}, else LAT.
  - On the Nth WAIT edge, sample ALU_RES and the flags into RSP_*, then go to RESP.
  - Undriven ALU outputs are captured as presented; the driver does no conversion.
- **RSP_LATE.** Set to 1 iff SPLIT∈{01,10} and REQ_GAP>=16.
- **RESP.**
  - RSP_VALID=1, ALU_CE=0, outputs held stable until RSP_READY.
  - On RSP_VALID&RSP_READY, go to IDLE, with RSP_VALID=0 the next cycle.
  - Back-to-back requests are not overlapped: one operation is outstanding at a time.
- **Latency.** Counted as accept edge to RSP_VALID high:
  - unsplit: 1+LAT (3);
  - unsplit two-stage: 1+MUL_LAT (4);
  - split: 2+GAP+LAT.
- **Request fields.** REQ_* are don't-care while REQ_READY=0. Changes during an operation have no effect.
- **Reset mid-operation.** Takes priority in any state, and ALU_INP_VALID drops to 00 in the same edge.

Test Plan:
1. **Unsplit add.** OPA=0xFF, OPB=0x01, MODE=1, CMD=0, SPLIT=00 → ALU_INP_VALID=11 for exactly 1 cycle; RSP_VALID 3 cycles after accept; RSP_RES=0x100; COUT=1; RSP_LATE=0.
2. **Two-stage multiply.** OPA=3, OPB=4, MODE=1, CMD=9 → WAIT lasts 3 cycles; RSP_RES=20 (4×5); RSP_VALID 4 cycles after accept.
3. **Split A-then-B.** SPLIT=01, GAP=5, OPA=0x0F, OPB=0x01, MODE=0, CMD=0 → INP_VALID sequence 01, 00×5, 10; RSP_RES=0x001; RSP_LATE=0; latency 9.
4. **Late split.** SPLIT=10, GAP=20 → INP_VALID sequence 10, 00×20, 01; RSP_LATE=1; RSP_FLAGS[0] reflects ALU_ERR=1.
5. **Response backpressure.** RSP_READY held 0 for 7 cycles → RSP_VALID stays 1 with RSP_RES/FLAGS unchanged; REQ_READY=0 throughout; REQ_READY=1 the cycle after the handshake.
6. **Reset mid-GAP.** RST asserted during GAP → next cycle all outputs 0, state IDLE, no RSP_VALID ever issued for that request; a following unsplit request completes normally.
